// File: rtl/memory_loader.sv
// Push-button memory programmer: sync + debounce, address load, wrap/count status.
// Define VERIFY_EN to add a read-back compare after each write (verify_err).
module memory_loader #(
    parameter int ADRS_W     = 8,
    parameter int DATA_W     = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset_N,
    input  logic              step_N,
    input  logic              cmd,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] mem_q,
    output logic [ADRS_W-1:0] adrs_out,
    output logic [DATA_W-1:0] data_out,
    output logic              wr_en,
    output logic              busy,
    output logic              wrap,
    output logic [ADRS_W:0]   write_count,
    output logic              verify_err
);

`ifdef VERIFY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_INCR, S_RELEASE, S_VWAIT, S_VCHECK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_INCR, S_RELEASE
    } state_t;
`endif

    state_t state_q;

    logic              sync1_q, sync2_q;
    logic              level_q, level_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              press;
    logic [ADRS_W-1:0] adrs_q;
    logic [DATA_W-1:0] data_q;
    logic              wr_en_q, busy_q, wrap_q, verr_q;
    logic [ADRS_W:0]   wcnt_q;

    // Level flips on the edge where the DEB_CYCLES-th differing sample lands.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == 16'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    assign press = level_q & ~level_d;

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= step_N;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state_q <= S_IDLE;
            adrs_q  <= '0;
            data_q  <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            wcnt_q  <= '0;
            verr_q  <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (press) begin
                        busy_q <= 1'b1;
                        if (cmd) begin
                            adrs_q  <= ADRS_W'(data_in);
                            state_q <= S_RELEASE;
                        end else begin
                            data_q  <= data_in;
                            wr_en_q <= 1'b1;
                            state_q <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
`ifdef VERIFY_EN
                    state_q <= S_VWAIT;
`else
                    state_q <= S_INCR;
`endif
                end
`ifdef VERIFY_EN
                S_VWAIT: begin
                    state_q <= S_VCHECK;
                end
                S_VCHECK: begin
                    if (mem_q != data_q) begin
                        verr_q <= 1'b1;
                    end
                    state_q <= S_INCR;
                end
`endif
                S_INCR: begin
                    adrs_q <= adrs_q + 1'b1;
                    if (&adrs_q) begin
                        wrap_q <= 1'b1;
                    end
                    if (!(&wcnt_q)) begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                    state_q <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (level_d) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifndef VERIFY_EN
    logic unused_mem_q;
    assign unused_mem_q = ^mem_q;
`endif

    assign adrs_out    = adrs_q;
    assign data_out    = data_q;
    assign wr_en       = wr_en_q;
    assign busy        = busy_q;
    assign wrap        = wrap_q;
    assign write_count = wcnt_q;
    assign verify_err  = verr_q;

endmodule

// File: tb/tb_memory_loader.sv
// Randomized bench for memory_loader against a per-press behavioural model.
// Build with VERIFY_EN defined to also exercise the read-back compare.
module tb_memory_loader;

    logic       clock = 1'b0;
    logic       reset_N;
    logic       step_N;
    logic       cmd;
    logic [7:0] data_in;
    logic [7:0] mem_q;
    logic [7:0] adrs_out;
    logic [7:0] data_out;
    logic       wr_en;
    logic       busy;
    logic       wrap;
    logic [8:0] write_count;
    logic       verify_err;

    memory_loader #(.ADRS_W(8), .DATA_W(8), .DEB_CYCLES(4)) dut (
        .clock(clock),
        .reset_N(reset_N),
        .step_N(step_N),
        .cmd(cmd),
        .data_in(data_in),
        .mem_q(mem_q),
        .adrs_out(adrs_out),
        .data_out(data_out),
        .wr_en(wr_en),
        .busy(busy),
        .wrap(wrap),
        .write_count(write_count),
        .verify_err(verify_err)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous memory with a registered read port
    logic [7:0] mem [256];
    bit         force_zero = 1'b0;

    always @(posedge clock) begin
        if (wr_en) mem[adrs_out] <= data_out;
        mem_q <= force_zero ? 8'h00 : mem[adrs_out];
    end

    logic [7:0] wq_adrs[$];
    logic [7:0] wq_data[$];
    int         wq_cyc[$];

    always @(negedge clock) begin
        if (wr_en) begin
            wq_adrs.push_back(adrs_out);
            wq_data.push_back(data_out);
            wq_cyc.push_back(cyc);
        end
    end

    // Reference state, advanced once per physical press
    int exp_adrs, exp_data, exp_cnt;
    bit exp_wrap, exp_verr;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_adrs = 0;
        exp_data = 0;
        exp_cnt  = 0;
        exp_wrap = 0;
        exp_verr = 0;
    endtask

    task automatic press(input bit c, input logic [7:0] d,
                         input int hold, input bit bounce);
        int fall_cyc, rise_cyc, n;
        wq_adrs.delete();
        wq_data.delete();
        wq_cyc.delete();
        @(negedge clock);
        cmd     = c;
        data_in = d;
        if (bounce) begin
            for (int i = 0; i < 20; i++) begin
                step_N = ((i / 2) % 2) != 0;
                @(negedge clock);
            end
        end
        step_N   = 1'b0;
        fall_cyc = cyc;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            if (i == 8) begin
                cmd     = 1'($urandom);
                data_in = 8'($urandom);
            end
        end
        step_N   = 1'b1;
        rise_cyc = cyc;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (busy && n < 100);
        chk("busy_lat", cyc - rise_cyc, 6);

        if (c) begin
            chk("n_writes_load", wq_adrs.size(), 0);
            exp_adrs = int'(d);
        end else begin
            chk("n_writes", wq_adrs.size(), 1);
            if (wq_adrs.size() > 0) begin
                chk("wr_adrs", wq_adrs[0], exp_adrs);
                chk("wr_data", wq_data[0], d);
                chk("wr_lat", wq_cyc[0] - fall_cyc, 6);
            end
            exp_data = int'(d);
            if (force_zero && d != 8'h00) exp_verr = 1;
            if (exp_adrs == 255) exp_wrap = 1;
            exp_adrs = (exp_adrs + 1) % 256;
            if (exp_cnt < 511) exp_cnt = exp_cnt + 1;
        end
        chk("adrs_out", adrs_out, exp_adrs);
        chk("data_out", data_out, exp_data);
        chk("write_count", write_count, exp_cnt);
        chk("wrap", wrap, exp_wrap);
        chk("verify_err", verify_err, exp_verr);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int n;
        reset_N = 1'b0;
        step_N  = 1'b1;
        cmd     = 1'b0;
        data_in = 8'h00;
        model_reset();
        #12;
        chk("rst_adrs", adrs_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_count", write_count, 0);
        chk("rst_verr", verify_err, 0);
        repeat (3) @(negedge clock);
        reset_N = 1'b1;
        repeat (3) @(negedge clock);

        press(1'b0, 8'hA5, 20, 1'b0);
        press(1'b0, 8'h5A, 12, 1'b1);
        press(1'b1, 8'hFF, 15, 1'b0);
        press(1'b0, 8'h33, 15, 1'b0);
        chk("wrapped", wrap, 1);
        press(1'b0, 8'h44, 1000, 1'b0);

        // Reset asserted mid-cycle while the write strobe is high
        @(negedge clock);
        cmd     = 1'b0;
        data_in = 8'h77;
        step_N  = 1'b0;
        n = 0;
        while (!wr_en && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("mwr_seen", wr_en, 1);
        #2 reset_N = 1'b0;
        #1;
        chk("mwr_wr_en", wr_en, 0);
        chk("mwr_adrs", adrs_out, 0);
        chk("mwr_busy", busy, 0);
        chk("mwr_count", write_count, 0);
        model_reset();
        step_N = 1'b1;
        repeat (5) @(negedge clock);
        reset_N = 1'b1;
        repeat (3) @(negedge clock);

        for (int k = 0; k < 40; k++) begin
            press($urandom_range(0, 3) == 0, 8'($urandom),
                  $urandom_range(8, 40), $urandom_range(0, 4) == 0);
        end

`ifdef VERIFY_EN
        press(1'b0, 8'h11, 12, 1'b0);
        force_zero = 1'b1;
        press(1'b0, 8'h3C, 12, 1'b0);
        force_zero = 1'b0;
        press(1'b0, 8'h22, 12, 1'b0);
        press(1'b0, 8'h99, 12, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/memory_loader.md
Name: memory_loader

Overview:
- Parametrised successor to the single-step memory programmer.
- Converts a raw push button plus slide-switch data into write cycles for the program memory while the shell is in program mode.
- Adds the following, all in the core clock domain:
  - input synchronisation and debounce;
  - an address-load command, so programming can start anywhere;
  - wrap and write-count status;
  - optional write-verify.
- Outputs feed the memory address, data and write-enable multiplexers and the 7-seg address/data display.

Parameters:
- ADRS_W, 8: address width; address wraps modulo 2^ADRS_W.
- DATA_W, 8: data width of data_in, data_out and mem_q.
- DEB_CYCLES, 4: consecutive stable synchronised samples needed to accept a button level change. Legal range 1..65535; the counter is 16 bits.

Ports:
- clock  in  1  core clock; all state on its rising edge.
- reset_N  in  1  asynchronous, active-low reset.
- step_N  in  1  raw push button, active low, asynchronous to clock.
- cmd  in  1  sampled at the press event: 0 = write data_in then increment address; 1 = load address from data_in.
- data_in  in  DATA_W  switch data, sampled at the press event.
- mem_q  in  DATA_W  memory read data; used only with VERIFY_EN.
- adrs_out  out  ADRS_W  current programming address.
- data_out  out  DATA_W  last captured write data.
- wr_en  out  1  memory write strobe, one clock wide.
- busy  out  1  high in every state except IDLE.
- wrap  out  1  sticky; set when the address increments from all-ones to 0.
- write_count  out  ADRS_W+1  writes since reset; saturates at all-ones.
- verify_err  out  1  sticky verify mismatch flag; constant 0 without VERIFY_EN.

Behaviour:
- Reset (asynchronous, immediate, including mid-operation):
  - adrs_out=0, data_out=0, wr_en=0, busy=0, wrap=0, write_count=0, verify_err=0;
  - both synchroniser flops=1, debounced level=1, debounce counter=0, state=IDLE.
- Synchroniser: two flops on step_N, giving 2 cycles of latency.
- Debounce:
  - Each cycle the synchronised sample differs from the debounced level, the counter increments.
  - When the counter reaches DEB_CYCLES, the debounced level flips and the counter clears.
  - Any cycle where sample equals the debounced level clears the counter.
  - Press event = debounced level going 1->0, as a single-cycle internal pulse.
  - Earliest press event is 2+DEB_CYCLES cycles after a clean edge on step_N.
- A button held through reset release yields a press event after 2+DEB_CYCLES cycles; this is intended.
- FSM states:
  - IDLE:
    - press & cmd=1: adrs_out <= data_in zero-extended or truncated to ADRS_W; go to RELEASE.
    - press & cmd=0: data_out <= data_in; go to WRITE.
    - no press: stay in IDLE.
  - WRITE: wr_en=1 for exactly this cycle, with adrs_out and data_out stable. Next state is INCR, or VWAIT with VERIFY_EN.
  - INCR:
    - adrs_out <= adrs_out+1 mod 2^ADRS_W;
    - if the old adrs_out was all-ones, set wrap;
    - write_count <= write_count+1 unless already all-ones;
    - go to RELEASE.
  - RELEASE: wait until the debounced level returns to 1, then go to IDLE.
- Press handling: press events are only acted on in IDLE. The debounced level is 0 throughout WRITE, INCR and RELEASE, so exactly one action occurs per physical press regardless of hold time.
- Sampling: cmd and data_in are sampled only in the press-event cycle; later switch changes have no effect.
- wr_en is never high outside WRITE. A write at address all-ones followed by wrap is legal and writes normally.

Optional Feature:
- Macro: VERIFY_EN.
- Defined:
  - Path is WRITE -> VWAIT -> VCHECK -> INCR.
  - VWAIT: wr_en=0, address held; allows one cycle for the synchronous memory's registered read.
  - VCHECK: if mem_q != data_out, set verify_err (sticky until reset).
  - The address increments in INCR regardless of the compare result.
- Not defined:
  - VWAIT and VCHECK do not exist; mem_q is ignored and verify_err is tied 0.
  - WRITE goes straight to INCR.

Test Plan:
- Reset check (DEB_CYCLES=4): assert reset_N=0 with step_N=1 -> all outputs 0, busy=0.
- Simple write: data_in=8'hA5, cmd=0, clean step_N low for 20 cycles, then high.
  - wr_en is one pulse, 6 cycles after the step_N fall, with adrs_out=8'h00 and data_out=8'hA5.
  - adrs_out=8'h01 and write_count=1 afterwards.
  - busy drops 6 cycles after step_N rises.
- Bounce rejection: step_N toggles every 2 cycles for 20 cycles, then stays low.
  - Exactly one wr_en pulse.
  - No write while bouncing; the write comes only after 4 stable cycles.
- Address load and wrap: cmd=1, data_in=8'hFF, press -> adrs_out=8'hFF with no wr_en. Then cmd=0 and press -> write at 8'hFF, adrs_out=8'h00, wrap=1.
- Long hold and mid-write reset:
  - Hold step_N low for 1000 cycles -> exactly one write.
  - Assert reset_N in the WRITE cycle -> wr_en falls with no clock edge needed, adrs_out=0, state IDLE.
- VERIFY_EN:
  - Bench memory returns data_out -> verify_err stays 0.
  - Bench forces mem_q=8'h00 against data_out=8'h3C -> verify_err=1 after VCHECK, adrs_out still increments.
  - verify_err stays 1 across further good writes.
